gbox_rx_align_ctrl: RTL



---
 rtl/gbox_pkg.sv | 24 ++
 rtl/gbox_match_cnt.sv | 32 +++
 rtl/gbox_rx_align_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/gbox_pkg.sv
// Shared types and constants for the gearbox RX word-alignment controller.
package gbox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_STEP,
    ST_LOCKED,
    ST_FAIL
  } gbox_align_st_e;

  localparam int unsigned GBOX_ERR_CNT_W = 8;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [GBOX_ERR_CNT_W-1:0] gbox_sat_inc(
    input logic [GBOX_ERR_CNT_W-1:0] v
  );
    return (&v) ? v : v + GBOX_ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/gbox_match_cnt.sv
// Consecutive training-word match counter; hit_c flags the increment that reaches the target.
module gbox_match_cnt
  import gbox_pkg::*;
#(
  parameter int unsigned PAR_MATCH_CNT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit_c
);

  localparam int unsigned CNT_W = $clog2(PAR_MATCH_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAR_MATCH_CNT - 1);

  logic [CNT_W-1:0] cnt;

  // Clear wins over increment so a mismatch always restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit_c = inc && (cnt == CNT_LAST);

endmodule

// File: rtl/gbox_rx_align_ctrl.sv
// RX word-alignment training FSM: loads the delay tap, sweeps bitslips and taps
// until the training word repeats, then monitors mismatches while locked.
module gbox_rx_align_ctrl
  import gbox_pkg::*;
#(
  parameter int unsigned PAR_DWID      = 10,
  parameter int unsigned PAR_TWID      = 6,
  parameter int unsigned PAR_SETTLE    = 8,
  parameter int unsigned PAR_MATCH_CNT = 16
) (
  input  logic                         core_clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [PAR_DWID-1:0]          train_pattern,
  input  logic [PAR_DWID-1:0]          rx_data,
  input  logic                         rx_dvalid,
  input  logic [PAR_TWID-1:0]          rx_dly_tap,
  output logic                         rx_bitslip_adj,
  output logic                         rx_dly_ld,
  output logic                         rx_dly_adj,
  output logic                         rx_dly_inc,
  output logic                         busy,
  output logic                         locked,
  output logic                         fail,
  output logic [$clog2(PAR_DWID)-1:0]  slip_pos,
  output logic [GBOX_ERR_CNT_W-1:0]    err_cnt
);

  localparam int unsigned SLIP_W = $clog2(PAR_DWID);
  localparam int unsigned SET_W  = $clog2(PAR_SETTLE + 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(PAR_DWID - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(PAR_SETTLE);

  gbox_align_st_e   state;
  logic [SET_W-1:0] settle_cnt;

  logic word_match_c;
  logic chk_valid_c;
  logic start_ok_c;
  logic mc_clr_c;
  logic mc_inc_c;
  logic mc_hit_c;

  assign word_match_c = (rx_data == train_pattern);
  assign chk_valid_c  = (state == ST_CHECK) && rx_dvalid;
  assign start_ok_c   = start && ((state == ST_IDLE) || (state == ST_LOCKED) ||
                                  (state == ST_FAIL));
  assign mc_inc_c     = chk_valid_c && word_match_c;
  assign mc_clr_c     = start_ok_c || (chk_valid_c && !word_match_c);

  gbox_match_cnt #(
    .PAR_MATCH_CNT (PAR_MATCH_CNT)
  ) u_match_cnt (
    .clk   (core_clk),
    .rst   (reset),
    .clr   (mc_clr_c),
    .inc   (mc_inc_c),
    .hit_c (mc_hit_c)
  );

  // Strobes default low every cycle so each is exactly one cycle wide.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      settle_cnt     <= '0;
      rx_bitslip_adj <= 1'b0;
      rx_dly_ld      <= 1'b0;
      rx_dly_adj     <= 1'b0;
      rx_dly_inc     <= 1'b1;
      busy           <= 1'b0;
      locked         <= 1'b0;
      fail           <= 1'b0;
      slip_pos       <= '0;
      err_cnt        <= '0;
    end else begin
      rx_bitslip_adj <= 1'b0;
      rx_dly_ld      <= 1'b0;
      rx_dly_adj     <= 1'b0;
      rx_dly_inc     <= 1'b1;

      unique case (state)
        ST_IDLE, ST_LOCKED, ST_FAIL: begin
          if (start) begin
            state     <= ST_LOAD;
            rx_dly_ld <= 1'b1;
            busy      <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
            slip_pos  <= '0;
            err_cnt   <= '0;
          end else if ((state == ST_LOCKED) && rx_dvalid && !word_match_c) begin
            err_cnt <= gbox_sat_inc(err_cnt);
          end
        end

        ST_LOAD, ST_SLIP, ST_STEP: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end

        // The cycle right after a strobe is not counted, so the gearbox
        // always gets a full PAR_SETTLE cycles on top of it.
        ST_SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        ST_CHECK: begin
          if (rx_dvalid) begin
            if (word_match_c) begin
              if (mc_hit_c) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
                busy   <= 1'b0;
              end
            end else if (slip_pos != SLIP_LAST) begin
              state          <= ST_SLIP;
              rx_bitslip_adj <= 1'b1;
              slip_pos       <= slip_pos + SLIP_W'(1);
            end else if (&rx_dly_tap) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state      <= ST_STEP;
              rx_dly_adj <= 1'b1;
              slip_pos   <= '0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
